// File: rtl/ysyx_22040125_axi_pkg.sv
// Shared AXI constants, FSM state encodings and burst helpers for the burst RAM.
package ysyx_22040125_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BEAT = 1'b1
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Only these lengths form a legal WRAP; anything else falls back to INCR.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ysyx_22040125_axi_burst_ram_if.sv
// AXI4 bus bundle between the crossbar (master) and the burst RAM (slave).
interface ysyx_22040125_axi_burst_ram_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/ysyx_22040125_axi_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts (reserved burst acts as INCR).
module ysyx_22040125_axi_addr_gen
    import ysyx_22040125_axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;

    always_comb begin
        w_step = ADDR_W'(1) << i_size;
        w_incr = i_addr + w_step;
        // Mask covers the whole wrap window of (len+1) beats.
        w_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
        o_next = w_incr;
        case (i_burst)
            BURST_FIXED: o_next = i_addr;
            BURST_INCR:  o_next = w_incr;
            BURST_WRAP: begin
                if (wrap_len_ok(i_len))
                    o_next = (i_addr & ~w_mask) | (w_incr & w_mask);
            end
            default:     o_next = w_incr;
        endcase
    end

endmodule

// File: rtl/ysyx_22040125_axi_burst_ram.sv
// AXI4 burst RAM slave with independent read and write FSMs.
// Define AXI_RAM_BOUNDS_CHK_EN to flag out-of-window beats with SLVERR instead of aliasing.
module ysyx_22040125_axi_burst_ram
    import ysyx_22040125_axi_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              ADDR_W    = 32,
    parameter int              ID_W      = 4,
    parameter int              DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    ysyx_22040125_axi_burst_ram_if.slave  axi
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                OFF_W     = $clog2(BYTES);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [2:0]        MAX_SIZE  = 3'(OFF_W);

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

`ifdef AXI_RAM_BOUNDS_CHK_EN
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * BYTES);
    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (ADDR_W+1)'(a - BASE_ADDR) >= MEM_BYTES;
    endfunction
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];

    // ---------------- read path ----------------
    r_state_e          r_rstate, w_rstate_nx;
    logic [ADDR_W-1:0] r_raddr, w_raddr_nx, w_rbeat_addr;
    logic [7:0]        r_rlen, r_rcnt;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst, r_rresp;
    logic [ID_W-1:0]   r_rid;
    logic              r_rerr, r_rlast;
    logic              w_ar_err, w_rbeat_err, w_rload;
    logic [DATA_W-1:0] r_rdata, w_rbeat_data;

    ysyx_22040125_axi_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
        .i_addr(r_raddr), .i_len(r_rlen), .i_size(r_rsize), .i_burst(r_rburst), .o_next(w_raddr_nx)
    );

    assign w_ar_err = (axi.arburst == 2'b11) || (axi.arsize > MAX_SIZE);

    always_comb begin
        w_rstate_nx = r_rstate;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                axi.arready = 1'b1;
                if (axi.arvalid) w_rstate_nx = R_BEAT;
            end
            R_BEAT: begin
                axi.rvalid = 1'b1;
                if (axi.rready && r_rlast) w_rstate_nx = R_IDLE;
            end
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    // The next beat is fetched into the output register on acceptance or handshake.
    always_comb begin
        w_rload      = 1'b0;
        w_rbeat_addr = w_raddr_nx;
        w_rbeat_err  = r_rerr;
        if (r_rstate == R_IDLE) begin
            w_rload      = axi.arvalid;
            w_rbeat_addr = axi.araddr;
            w_rbeat_err  = w_ar_err;
        end else if (axi.rready && !r_rlast) begin
            w_rload = 1'b1;
        end
        w_rbeat_data = r_mem[word_idx(w_rbeat_addr)];
`ifdef AXI_RAM_BOUNDS_CHK_EN
        if (out_of_range(w_rbeat_addr)) begin
            w_rbeat_data = '0;
            w_rbeat_err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rid    <= '0;
            r_rerr   <= 1'b0;
            r_rcnt   <= '0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nx;
            if (r_rstate == R_IDLE && axi.arvalid) begin
                r_raddr  <= axi.araddr;
                r_rlen   <= axi.arlen;
                r_rsize  <= axi.arsize;
                r_rburst <= axi.arburst;
                r_rid    <= axi.arid;
                r_rerr   <= w_ar_err;
                r_rcnt   <= '0;
                r_rlast  <= (axi.arlen == 8'd0);
            end else if (r_rstate == R_BEAT && axi.rready) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_raddr <= w_raddr_nx;
                    r_rcnt  <= r_rcnt + 8'd1;
                    r_rlast <= (r_rcnt + 8'd1 == r_rlen);
                end
            end
            if (w_rload) begin
                r_rdata <= w_rbeat_data;
                r_rresp <= w_rbeat_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign axi.rid   = r_rid;
    assign axi.rdata = r_rdata;
    assign axi.rresp = r_rresp;
    assign axi.rlast = r_rlast;

    // ---------------- write path ----------------
    w_state_e          r_wstate, w_wstate_nx;
    logic [ADDR_W-1:0] r_waddr, w_waddr_nx;
    logic [7:0]        r_wlen, r_wcnt;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic [ID_W-1:0]   r_wid;
    logic              r_werr, w_aw_err, w_wfinal, w_woob, w_wen;

    ysyx_22040125_axi_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
        .i_addr(r_waddr), .i_len(r_wlen), .i_size(r_wsize), .i_burst(r_wburst), .o_next(w_waddr_nx)
    );

    assign w_aw_err = (axi.awburst == 2'b11) || (axi.awsize > MAX_SIZE);
    assign w_wfinal = (r_wcnt == r_wlen);
`ifdef AXI_RAM_BOUNDS_CHK_EN
    assign w_woob   = out_of_range(r_waddr);
`else
    assign w_woob   = 1'b0;
`endif
    assign w_wen    = (r_wstate == W_DATA) && axi.wvalid && !w_woob;

    always_comb begin
        w_wstate_nx = r_wstate;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                axi.awready = 1'b1;
                if (axi.awvalid) w_wstate_nx = W_DATA;
            end
            W_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid && w_wfinal) w_wstate_nx = W_RESP;
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) w_wstate_nx = W_IDLE;
            end
            default: w_wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wid    <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nx;
            if (r_wstate == W_IDLE && axi.awvalid) begin
                r_waddr  <= axi.awaddr;
                r_wlen   <= axi.awlen;
                r_wsize  <= axi.awsize;
                r_wburst <= axi.awburst;
                r_wid    <= axi.awid;
                r_wcnt   <= '0;
                r_werr   <= w_aw_err;
            end else if (r_wstate == W_DATA && axi.wvalid) begin
                // Beat count ends the burst; a wlast disagreement only taints the response.
                if ((axi.wlast != w_wfinal) || w_woob) r_werr <= 1'b1;
                if (!w_wfinal) begin
                    r_waddr <= w_waddr_nx;
                    r_wcnt  <= r_wcnt + 8'd1;
                end
            end
        end
    end

    // Storage has no reset so contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (aresetn && w_wen) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi.wstrb[b]) r_mem[word_idx(r_waddr)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    assign axi.bid   = r_wid;
    assign axi.bresp = r_werr ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_ysyx_22040125_axi_burst_ram.sv
// Scoreboard bench for the AXI burst RAM: a flat byte-level memory model predicts every R and B beat.
module tb_ysyx_22040125_axi_burst_ram;
    localparam int          DATA_W = 64;
    localparam int          ADDR_W = 32;
    localparam int          ID_W   = 4;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    ysyx_22040125_axi_burst_ram_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ysyx_22040125_axi_burst_ram #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .axi(bus)
    );

    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          r_seen = 0;
    logic [63:0] mdl [DEPTH];
    rexp_t       rq [$];
    bexp_t       bq [$];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    bit          rdy_rand = 0;
    bit          r_hold = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Beat address straight from the burst definition: start, start+i*step, or a slot inside the wrap window.
    function automatic logic [31:0] beat_addr(logic [31:0] start, logic [7:0] len, logic [2:0] size,
                                              logic [1:0] burst, int i);
        longint s     = longint'(start);
        longint step  = longint'(1) << size;
        longint total = step * (longint'(len) + 1);
        longint lower;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            lower = (s / total) * total;
            return 32'(lower + ((s - lower + i * step) % total));
        end
        return 32'(s + i * step);
    endfunction

    // ---------------- monitors ----------------
    always @(negedge aclk) begin
        rexp_t e;
        if (aresetn && bus.rvalid && bus.rready) begin
            r_seen++;
            if (rq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL r_unexpected: got beat %h, expected none", bus.rdata);
            end else begin
                e = rq.pop_front();
                check("r_data", bus.rdata, e.data);
                check("r_id_resp_last", 64'({bus.rid, bus.rresp, bus.rlast}), 64'({e.id, e.resp, e.last}));
            end
        end
    end

    always @(negedge aclk) begin
        bexp_t e;
        if (aresetn && bus.bvalid && bus.bready) begin
            if (bq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected: got bresp %h, expected none", bus.bresp);
            end else begin
                e = bq.pop_front();
                check("b_id_resp", 64'({bus.bid, bus.bresp}), 64'({e.id, e.resp}));
            end
        end
    end

    initial begin
        bus.rready = 1'b0;
        bus.bready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            bus.rready = r_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.bready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---------------- drivers ----------------
    task automatic do_read(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        bit err = (burst == 2'b11) || (size > 3'd3);
        int n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] off = beat_addr(a, len, size, burst, i) - BASE;
            rexp_t e;
            e.id = id;
            e.last = (i == int'(len));
`ifdef AXI_RAM_BOUNDS_CHK_EN
            if (off >= 32'(DEPTH * 8)) begin
                e.data = '0; e.resp = 2'b10;
            end else begin
                e.data = mdl[off / 8]; e.resp = err ? 2'b10 : 2'b00;
            end
`else
            e.data = mdl[(off / 8) % DEPTH];
            e.resp = err ? 2'b10 : 2'b00;
`endif
            rq.push_back(e);
        end
        bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        @(negedge aclk);
        while (!bus.arready && n < 2000) begin n++; @(negedge aclk); end
        if (n >= 2000) begin n_cmp++; n_bad++; $display("FAIL ar_timeout: got arready 0, expected 1"); end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic do_write(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [2:0] size,
                            logic [1:0] burst, bit bad_last);
        bit err = (burst == 2'b11) || (size > 3'd3) || bad_last;
        int n = 0;
        bexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] off = beat_addr(a, len, size, burst, i) - BASE;
            int w = int'((off / 8) % DEPTH);
`ifdef AXI_RAM_BOUNDS_CHK_EN
            if (off >= 32'(DEPTH * 8)) begin err = 1; continue; end
`endif
            for (int b = 0; b < 8; b++) if (ws[i][b]) mdl[w][b*8 +: 8] = wd[i][b*8 +: 8];
        end
        e.id = id; e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        @(negedge aclk);
        while (!bus.awready && n < 2000) begin n++; @(negedge aclk); end
        if (n >= 2000) begin n_cmp++; n_bad++; $display("FAIL aw_timeout: got awready 0, expected 1"); end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = wd[i]; bus.wstrb = ws[i];
            bus.wlast = (i == int'(len)) && !bad_last;
            bus.wvalid = 1'b1;
            n = 0;
            @(negedge aclk);
            while (!bus.wready && n < 2000) begin n++; @(negedge aclk); end
            if (n >= 2000) begin n_cmp++; n_bad++; $display("FAIL w_timeout: got wready 0, expected 1"); end
            @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin @(posedge aclk); n++; end
        #1;
        if (n >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d r / %0d b pending, expected 0", rq.size(), bq.size());
        end
    endtask

    task automatic wait_seen(int target);
        int n = 0;
        while (r_seen < target && n < 200) begin @(negedge aclk); #1; n++; end
        if (n >= 200) begin n_cmp++; n_bad++; $display("FAIL beat_wait: got %0d beats, expected %0d", r_seen, target); end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] old;
        int base;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ready", 64'({bus.arready, bus.awready}), 64'(2'b11));
        check("rst_valid", 64'({bus.rvalid, bus.wready, bus.bvalid, bus.rlast}), 64'(0));
        check("rst_rdata", bus.rdata, 64'(0));
        check("rst_id_resp", 64'({bus.rid, bus.bid, bus.rresp, bus.bresp}), 64'(0));
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Preload words 0..63 with index-tagged data, then read them all back.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) begin wd[i] = {32'(k * 8 + i), $urandom}; ws[i] = 8'hFF; end
            do_write(4'(k), BASE + 32'(k * 64), 8'd7, 3'd3, 2'b01, 0);
        end
        for (int k = 0; k < 8; k++) do_read(4'(k + 8), BASE + 32'(k * 64), 8'd7, 3'd3, 2'b01);
        drain();

        // INCR write len=3 at the base, read back.
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(4'h3, BASE, 8'd3, 3'd3, 2'b01, 0);
        do_read(4'h5, BASE, 8'd3, 3'd3, 2'b01);
        // WRAP len=3 from offset 0x10: 0x10,0x18,0x00,0x08.
        do_read(4'h6, BASE + 32'h10, 8'd3, 3'd3, 2'b10);
        drain();

        // Half-word strobe over a zeroed word.
        wd[0] = '0; ws[0] = 8'hFF;
        do_write(4'h1, BASE + 32'h40, 8'd0, 3'd3, 2'b01, 0);
        wd[0] = '1; ws[0] = 8'h0F;
        do_write(4'h2, BASE + 32'h40, 8'd0, 3'd3, 2'b01, 0);
        do_read(4'h7, BASE + 32'h40, 8'd0, 3'd3, 2'b01);
        drain();
        check("strobe_model", mdl[8], 64'h0000_0000_FFFF_FFFF);

        // Reset during beat 3 of an 8-beat read.
        base = r_seen;
        do_read(4'h9, BASE + 32'h80, 8'd7, 3'd3, 2'b01);
        wait_seen(base + 2);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        rq.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("midrst_rvalid_rlast", 64'({bus.rvalid, bus.rlast}), 64'(0));
        check("midrst_arready", 64'(bus.arready), 64'(1));
        check("midrst_rdata", bus.rdata, 64'(0));
        @(posedge aclk); #1;
        do_read(4'hA, BASE + 32'h80, 8'd7, 3'd3, 2'b01);
        drain();

        // Stall mid-burst while a write hits the word held in the output register.
        base = r_seen;
        do_read(4'hB, BASE + 32'h100, 8'd3, 3'd3, 2'b01);
        wait_seen(base + 1);
        r_hold = 1;
        @(posedge aclk); #1;
        old = mdl[33];
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge aclk);
                    check("stall_rdata", bus.rdata, old);
                    check("stall_rvalid_rlast", 64'({bus.rvalid, bus.rlast}), 64'(2'b10));
                end
            end
            begin
                wd[0] = ~old; ws[0] = 8'hFF;
                do_write(4'hC, BASE + 32'h108, 8'd0, 3'd3, 2'b01, 0);
            end
        join
        @(posedge aclk); #1;
        r_hold = 0;
        drain();
        do_read(4'hD, BASE + 32'h108, 8'd0, 3'd3, 2'b01);
        drain();

        // One past the top of memory.
        do_read(4'hE, BASE + 32'(DEPTH * 8), 8'd0, 3'd3, 2'b01);
        drain();

        // wlast dropped, reserved burst, oversize, FIXED, narrow byte lanes.
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(4'h4, BASE + 32'h140, 8'd1, 3'd3, 2'b01, 1);
        do_write(4'h5, BASE + 32'h150, 8'd1, 3'd3, 2'b11, 0);
        do_read(4'h6, BASE + 32'h140, 8'd3, 3'd3, 2'b11);
        do_read(4'h7, BASE + 32'h160, 8'd0, 3'd4, 2'b01);
        drain();
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(4'h8, BASE + 32'h168, 8'd3, 3'd3, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'(1 << ((1 + i) % 8)); end
        do_write(4'h9, BASE + 32'h171, 8'd3, 3'd0, 2'b01, 0);
        do_read(4'hA, BASE + 32'h168, 8'd1, 3'd3, 2'b01);
        drain();

        // Randomised traffic with random back-pressure.
        rdy_rand = 1;
        for (int t = 0; t < 60; t++) begin
            logic [2:0]  sz  = 3'($urandom_range(0, 3));
            logic [7:0]  ln  = 8'($urandom_range(0, 7));
            logic [1:0]  bu  = 2'($urandom_range(0, 2));
            logic [31:0] ad  = BASE + (32'($urandom_range(0, 447)) & ~((32'd1 << sz) - 1));
            if ($urandom_range(0, 1) == 0) begin
                do_read(4'($urandom), ad, ln, sz, bu);
            end else begin
                drain();
                for (int i = 0; i <= int'(ln); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
                do_write(4'($urandom), ad, ln, sz, bu, $urandom_range(0, 7) == 0);
            end
        end
        drain();
        rdy_rand = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
